// File: rtl/mdu_sequencer_if.sv
// E-stage <-> MDU request/result bundle: one-cycle start with operands, flush, busy and HI/LO.
// The master (pipeline) drives requests and cancel; the slave (sequencer) returns busy, hi and lo.
interface mdu_sequencer_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, cancel,
        input  busy, hi, lo
    );

    modport slave (
        input  start, op, a, b, cancel,
        output busy, hi, lo
    );
endinterface

// File: rtl/mdu_sequencer.sv
// Purpose: P7 E-stage multiply/divide sequencer owning HI/LO; MADD/MSUB family only when MDU_MADD_EN is defined.
// Latency: MUL_CYCLES (mul class) or DIV_CYCLES (div class) busy cycles; MTHI/MTLO visible one cycle after accept.
// Backpressure: no stall input; start while busy or with cancel is dropped, the hazard unit holds D on start || busy.
module mdu_sequencer #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic            clk,
    input  logic            reset_n,
    mdu_sequencer_if.slave  mdu
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8,
        OP_MSUB  = 4'd9,
        OP_MSUBU = 4'd10
    } op_t;

    // How the pending 64-bit value lands in {hi,lo} at the end of the window.
    typedef enum logic [1:0] {
        CM_LOAD = 2'd0,
        CM_ADD  = 2'd1,
        CM_SUB  = 2'd2,
        CM_NONE = 2'd3
    } commit_t;

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] pend_hi, pend_hi_nxt;
    logic [31:0] pend_lo, pend_lo_nxt;
    commit_t     pend_mode, pend_mode_nxt;
    logic [31:0] hi_q, hi_nxt;
    logic [31:0] lo_q, lo_nxt;

    logic        accept;
    logic        is_mul, mul_signed;
    logic        is_div, div_signed;
    logic        is_mthi, is_mtlo;
    commit_t     mul_mode;

    always_comb begin
        is_mul     = 1'b0;
        mul_signed = 1'b0;
        mul_mode   = CM_LOAD;
        is_div     = 1'b0;
        div_signed = 1'b0;
        is_mthi    = 1'b0;
        is_mtlo    = 1'b0;
        case (mdu.op)
            OP_MULT:  begin is_mul = 1'b1; mul_signed = 1'b1; end
            OP_MULTU: is_mul = 1'b1;
            OP_DIV:   begin is_div = 1'b1; div_signed = 1'b1; end
            OP_DIVU:  is_div = 1'b1;
            OP_MTHI:  is_mthi = 1'b1;
            OP_MTLO:  is_mtlo = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD:  begin is_mul = 1'b1; mul_signed = 1'b1; mul_mode = CM_ADD; end
            OP_MADDU: begin is_mul = 1'b1; mul_mode = CM_ADD; end
            OP_MSUB:  begin is_mul = 1'b1; mul_signed = 1'b1; mul_mode = CM_SUB; end
            OP_MSUBU: begin is_mul = 1'b1; mul_mode = CM_SUB; end
`endif
            default:  ;
        endcase
    end

    assign accept = mdu.start && !mdu.cancel && (state == IDLE);

    // Signedness handled by extending to 64 bits so one multiplier serves both variants.
    logic [63:0] mul_x, mul_y, product;
    assign mul_x   = {{32{mul_signed & mdu.a[31]}}, mdu.a};
    assign mul_y   = {{32{mul_signed & mdu.b[31]}}, mdu.b};
    assign product = mul_x * mul_y;

    // Sign-magnitude divide: avoids the -2^31 / -1 overflow corner and gives
    // truncation toward zero with the remainder following the dividend.
    logic        neg_a, neg_b, div_by_zero;
    logic [31:0] mag_a, mag_b, divisor;
    logic [31:0] q_mag, r_mag, quot, rem;
    assign neg_a       = div_signed & mdu.a[31];
    assign neg_b       = div_signed & mdu.b[31];
    assign mag_a       = neg_a ? (32'd0 - mdu.a) : mdu.a;
    assign mag_b       = neg_b ? (32'd0 - mdu.b) : mdu.b;
    assign div_by_zero = (mdu.b == 32'd0);
    assign divisor     = div_by_zero ? 32'd1 : mag_b;
    assign q_mag       = mag_a / divisor;
    assign r_mag       = mag_a % divisor;
    assign quot        = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
    assign rem         = neg_a ? (32'd0 - r_mag) : r_mag;

    logic [63:0] commit_val;
    always_comb begin
        commit_val = {pend_hi, pend_lo};
        case (pend_mode)
            CM_NONE: commit_val = {hi_q, lo_q};
`ifdef MDU_MADD_EN
            CM_ADD:  commit_val = {hi_q, lo_q} + {pend_hi, pend_lo};
            CM_SUB:  commit_val = {hi_q, lo_q} - {pend_hi, pend_lo};
`endif
            default: commit_val = {pend_hi, pend_lo};
        endcase
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        pend_hi_nxt   = pend_hi;
        pend_lo_nxt   = pend_lo;
        pend_mode_nxt = pend_mode;
        hi_nxt        = hi_q;
        lo_nxt        = lo_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        {pend_hi_nxt, pend_lo_nxt} = product;
                        pend_mode_nxt = mul_mode;
                        cnt_nxt       = MUL_LOAD;
                        state_nxt     = MUL;
                    end else if (is_div) begin
                        pend_hi_nxt   = rem;
                        pend_lo_nxt   = quot;
                        pend_mode_nxt = div_by_zero ? CM_NONE : CM_LOAD;
                        cnt_nxt       = DIV_LOAD;
                        state_nxt     = DIV;
                    end else if (is_mthi) begin
                        hi_nxt = mdu.a;
                    end else if (is_mtlo) begin
                        lo_nxt = mdu.a;
                    end
                end
            end
            MUL, DIV: begin
                // A flush on the final edge still wins: the result never reaches HI/LO.
                if (mdu.cancel) begin
                    state_nxt     = IDLE;
                    cnt_nxt       = 4'd0;
                    pend_hi_nxt   = 32'd0;
                    pend_lo_nxt   = 32'd0;
                    pend_mode_nxt = CM_LOAD;
                end else if (cnt == 4'd1) begin
                    {hi_nxt, lo_nxt} = commit_val;
                    state_nxt        = IDLE;
                    cnt_nxt          = 4'd0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            pend_hi   <= 32'd0;
            pend_lo   <= 32'd0;
            pend_mode <= CM_LOAD;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pend_hi   <= pend_hi_nxt;
            pend_lo   <= pend_lo_nxt;
            pend_mode <= pend_mode_nxt;
            hi_q      <= hi_nxt;
            lo_q      <= lo_nxt;
        end
    end

    assign mdu.busy = (state != IDLE);
    assign mdu.hi   = hi_q;
    assign mdu.lo   = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: directed scenarios plus randomized ops against a transaction-level HI/LO model.
module tb_mdu_sequencer;
    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic clk;
    logic reset_n;
    int   tests;
    int   fails;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_sequencer_if mdu_if ();

    mdu_sequencer #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .mdu     (mdu_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Architectural effect of one accepted op; returns how many cycles busy must stay high.
    function automatic int model_exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] acc;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        acc = {m_hi, m_lo};
        case (op)
            4'd1: begin {m_hi, m_lo} = 64'(sa * sb); return MUL_N; end
            4'd2: begin {m_hi, m_lo} = 64'(ua * ub); return MUL_N; end
            4'd3: begin
                if (b != 32'd0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
                return DIV_N;
            end
            4'd4: begin
                if (b != 32'd0) begin m_lo = 32'(ua / ub); m_hi = 32'(ua % ub); end
                return DIV_N;
            end
            4'd5: begin m_hi = a; return 0; end
            4'd6: begin m_lo = a; return 0; end
`ifdef MDU_MADD_EN
            4'd7:  begin {m_hi, m_lo} = acc + 64'(sa * sb); return MUL_N; end
            4'd8:  begin {m_hi, m_lo} = acc + 64'(ua * ub); return MUL_N; end
            4'd9:  begin {m_hi, m_lo} = acc - 64'(sa * sb); return MUL_N; end
            4'd10: begin {m_hi, m_lo} = acc - 64'(ua * ub); return MUL_N; end
`endif
            default: return 0;
        endcase
    endfunction

    // Called at a negedge; issues op, checks every busy cycle, and leaves off at the negedge after busy falls.
    // intr_cyc >= 0 injects a start of intr_op during that busy cycle, which must be ignored.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int intr_cyc, input logic [3:0] intr_op);
        int          lat;
        logic [63:0] old;
        old = {m_hi, m_lo};
        mdu_if.start  = 1'b1;
        mdu_if.op     = op;
        mdu_if.a      = a;
        mdu_if.b      = b;
        mdu_if.cancel = 1'b0;
        lat = model_exec(op, a, b);
        @(negedge clk);
        mdu_if.start = 1'b0;
        for (int k = 0; k < lat; k++) begin
            chk({tag, "_busy"}, 64'(mdu_if.busy), 64'd1);
            chk({tag, "_hold"}, {mdu_if.hi, mdu_if.lo}, old);
            if (k == intr_cyc) begin
                mdu_if.start = 1'b1;
                mdu_if.op    = intr_op;
                mdu_if.a     = $urandom;
                mdu_if.b     = $urandom;
            end else begin
                mdu_if.start = 1'b0;
            end
            @(negedge clk);
        end
        mdu_if.start = 1'b0;
        chk({tag, "_idle"}, 64'(mdu_if.busy), 64'd0);
        chk({tag, "_hilo"}, {mdu_if.hi, mdu_if.lo}, {m_hi, m_lo});
    endtask

    // Flush during busy cycle cyc (1-based): busy drops on the next edge and HI/LO stay put.
    task automatic run_cancel(input string tag, input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input int cyc);
        mdu_if.start  = 1'b1;
        mdu_if.op     = op;
        mdu_if.a      = a;
        mdu_if.b      = b;
        mdu_if.cancel = 1'b0;
        @(negedge clk);
        mdu_if.start = 1'b0;
        for (int k = 1; k <= cyc; k++) begin
            chk({tag, "_busy"}, 64'(mdu_if.busy), 64'd1);
            if (k == cyc) mdu_if.cancel = 1'b1;
            @(negedge clk);
        end
        mdu_if.cancel = 1'b0;
        chk({tag, "_drop"}, 64'(mdu_if.busy), 64'd0);
        chk({tag, "_hilo"}, {mdu_if.hi, mdu_if.lo}, {m_hi, m_lo});
    endtask

    // start together with cancel in IDLE must leave no trace.
    task automatic run_start_cancel(input string tag, input logic [3:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
        mdu_if.start  = 1'b1;
        mdu_if.cancel = 1'b1;
        mdu_if.op     = op;
        mdu_if.a      = a;
        mdu_if.b      = b;
        @(negedge clk);
        mdu_if.start  = 1'b0;
        mdu_if.cancel = 1'b0;
        chk({tag, "_busy"}, 64'(mdu_if.busy), 64'd0);
        chk({tag, "_hilo"}, {mdu_if.hi, mdu_if.lo}, {m_hi, m_lo});
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'($urandom_range(1, 9));
            2:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 9));
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        tests = 0;
        fails = 0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        reset_n       = 1'b0;
        mdu_if.start  = 1'b0;
        mdu_if.op     = 4'd0;
        mdu_if.a      = 32'd0;
        mdu_if.b      = 32'd0;
        mdu_if.cancel = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(mdu_if.busy), 64'd0);
        chk("rst_hilo", {mdu_if.hi, mdu_if.lo}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, -1, 4'd0);
        chk("mult_const", {mdu_if.hi, mdu_if.lo}, 64'hFFFF_FFFF_FFFF_FFFA);

        run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, -1, 4'd0);
        chk("div_const", {mdu_if.hi, mdu_if.lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        run_op("divu0", 4'd4, 32'd7, 32'd0, -1, 4'd0);
        chk("divu0_const", {mdu_if.hi, mdu_if.lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        run_op("mthi", 4'd5, 32'h1234_5678, 32'd0, -1, 4'd0);
        run_op("mtlo", 4'd6, 32'd0, 32'd0, -1, 4'd0);
        run_op("maddu", 4'd8, 32'hFFFF_FFFF, 32'd2, -1, 4'd0);
`ifdef MDU_MADD_EN
        chk("maddu_const", {mdu_if.hi, mdu_if.lo}, 64'h1234_5679_FFFF_FFFE);
`else
        chk("maddu_const", {mdu_if.hi, mdu_if.lo}, 64'h1234_5678_0000_0000);
`endif

        run_cancel("cancel3", 4'd1, 32'h0001_0003, 32'h0002_0005, 3);
        run_start_cancel("stcan_mthi", 4'd5, 32'hDEAD_BEEF, 32'd0);
        run_start_cancel("stcan_mult", 4'd1, 32'd9, 32'd9);

        // Intruding DIVU must be ignored, then MTLO is issued the cycle busy falls.
        run_op("mult_intr", 4'd1, 32'h0000_1234, 32'hFFFF_0001, 1, 4'd4);
        run_op("mtlo_b2b", 4'd6, 32'hCAFE_F00D, 32'd0, -1, 4'd0);
        chk("mtlo_b2b_const", 64'(mdu_if.lo), 64'hCAFE_F00D);

        for (int i = 0; i < 60; i++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            int          sel;
            op  = 4'($urandom_range(0, 15));
            a   = rand_operand();
            b   = rand_operand();
            sel = $urandom_range(0, 9);
            if (sel == 0)
                run_cancel("rnd_cancel", ($urandom_range(0, 1) == 0) ? 4'd1 : 4'd3, a, b,
                           $urandom_range(1, MUL_N));
            else if (sel == 1)
                run_start_cancel("rnd_stcan", op, a, b);
            else if (sel <= 3)
                run_op("rnd_intr", op, a, b, $urandom_range(0, MUL_N - 1), 4'($urandom_range(0, 15)));
            else
                run_op("rnd", op, a, b, -1, 4'd0);
        end

        run_op("pre_rst_hi", 4'd5, 32'hA5A5_0001, 32'd0, -1, 4'd0);
        run_op("pre_rst_lo", 4'd6, 32'h5A5A_0002, 32'd0, -1, 4'd0);
        mdu_if.start = 1'b1;
        mdu_if.op    = 4'd3;
        mdu_if.a     = 32'd100;
        mdu_if.b     = 32'd7;
        @(negedge clk);
        mdu_if.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_div_busy", 64'(mdu_if.busy), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_busy", 64'(mdu_if.busy), 64'd0);
        chk("async_rst_hilo", {mdu_if.hi, mdu_if.lo}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        run_op("post_rst", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 4'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
